// File: rtl/ds_es_pipe_if.sv
// rtl/ds_es_pipe_if.sv - decode/execute pipeline register bundle
interface ds_es_pipe_if #(
    parameter int AWIDTH  = 5,
    parameter int DWIDTH  = 32,
    parameter int PCWIDTH = 32,
    parameter int ALUOPW  = 4,
    parameter int CNTW    = 16
) ();
    logic               ds_i_valid;
    logic [PCWIDTH-1:0] ds_i_pc;
    logic [AWIDTH-1:0]  ds_i_addr_rs1;
    logic [AWIDTH-1:0]  ds_i_addr_rs2;
    logic [AWIDTH-1:0]  ds_i_addr_rd;
    logic [DWIDTH-1:0]  ds_i_data_rs1;
    logic [DWIDTH-1:0]  ds_i_data_rs2;
    logic [DWIDTH-1:0]  ds_i_imm;
    logic [ALUOPW-1:0]  ds_i_alu_op;
    logic               ds_i_alusrc;
    logic               ds_i_regwrite;
    logic               ds_i_memread;
    logic               ds_i_memwrite;
    logic               ds_i_branch;
    logic               es_i_stall;
    logic               es_i_flush;
    logic               ds_o_ready;
    logic               ds_es_o_valid;
    logic [PCWIDTH-1:0] ds_es_o_pc;
    logic [AWIDTH-1:0]  ds_es_o_addr_rs1;
    logic [AWIDTH-1:0]  ds_es_o_addr_rs2;
    logic [AWIDTH-1:0]  ds_es_o_addr_rd;
    logic [DWIDTH-1:0]  ds_es_o_data_rs1;
    logic [DWIDTH-1:0]  ds_es_o_data_rs2;
    logic [DWIDTH-1:0]  ds_es_o_imm;
    logic [ALUOPW-1:0]  ds_es_o_alu_op;
    logic               ds_es_o_alusrc;
    logic               ds_es_o_regwrite;
    logic               ds_es_o_memread;
    logic               ds_es_o_memwrite;
    logic               ds_es_o_branch;
    logic [CNTW-1:0]    ds_es_o_stall_cnt;
    logic [CNTW-1:0]    ds_es_o_flush_cnt;

    modport slave (
        input  ds_i_valid, ds_i_pc, ds_i_addr_rs1, ds_i_addr_rs2, ds_i_addr_rd,
               ds_i_data_rs1, ds_i_data_rs2, ds_i_imm, ds_i_alu_op,
               ds_i_alusrc, ds_i_regwrite, ds_i_memread, ds_i_memwrite, ds_i_branch,
               es_i_stall, es_i_flush,
        output ds_o_ready, ds_es_o_valid, ds_es_o_pc, ds_es_o_addr_rs1, ds_es_o_addr_rs2,
               ds_es_o_addr_rd, ds_es_o_data_rs1, ds_es_o_data_rs2, ds_es_o_imm,
               ds_es_o_alu_op, ds_es_o_alusrc, ds_es_o_regwrite, ds_es_o_memread,
               ds_es_o_memwrite, ds_es_o_branch, ds_es_o_stall_cnt, ds_es_o_flush_cnt
    );

    modport master (
        output ds_i_valid, ds_i_pc, ds_i_addr_rs1, ds_i_addr_rs2, ds_i_addr_rd,
               ds_i_data_rs1, ds_i_data_rs2, ds_i_imm, ds_i_alu_op,
               ds_i_alusrc, ds_i_regwrite, ds_i_memread, ds_i_memwrite, ds_i_branch,
               es_i_stall, es_i_flush,
        input  ds_o_ready, ds_es_o_valid, ds_es_o_pc, ds_es_o_addr_rs1, ds_es_o_addr_rs2,
               ds_es_o_addr_rd, ds_es_o_data_rs1, ds_es_o_data_rs2, ds_es_o_imm,
               ds_es_o_alu_op, ds_es_o_alusrc, ds_es_o_regwrite, ds_es_o_memread,
               ds_es_o_memwrite, ds_es_o_branch, ds_es_o_stall_cnt, ds_es_o_flush_cnt
    );
endinterface

// File: rtl/ds_es_pipe.sv
// rtl/ds_es_pipe.sv - decode-to-execute pipeline register with stall/flush and event counters
module ds_es_pipe #(
    parameter int AWIDTH  = 5,
    parameter int DWIDTH  = 32,
    parameter int PCWIDTH = 32,
    parameter int ALUOPW  = 4,
    parameter int CNTW    = 16
) (
    input  logic         ds_i_clk,
    input  logic         ds_i_rst,
    ds_es_pipe_if.slave  bus
);
    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    logic               valid_q,   valid_d;
    logic [PCWIDTH-1:0] pc_q,      pc_d;
    logic [AWIDTH-1:0]  rs1_q,     rs1_d;
    logic [AWIDTH-1:0]  rs2_q,     rs2_d;
    logic [AWIDTH-1:0]  rd_q,      rd_d;
    logic [DWIDTH-1:0]  d1_q,      d1_d;
    logic [DWIDTH-1:0]  d2_q,      d2_d;
    logic [DWIDTH-1:0]  imm_q,     imm_d;
    logic [ALUOPW-1:0]  op_q,      op_d;
    // {alusrc, regwrite, memread, memwrite, branch}
    logic [4:0]         ctrl_q,    ctrl_d;
    logic [CNTW-1:0]    scnt_q,    scnt_d;
    logic [CNTW-1:0]    fcnt_q,    fcnt_d;

    logic [4:0] ctrl_in;
    assign ctrl_in = {bus.ds_i_alusrc, bus.ds_i_regwrite, bus.ds_i_memread,
                      bus.ds_i_memwrite, bus.ds_i_branch};

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        imm_d   = imm_q;
        op_d    = op_q;
        ctrl_d  = ctrl_q;
        if (bus.es_i_flush) begin
            valid_d = 1'b0;
            pc_d    = '0;
            rs1_d   = '0;
            rs2_d   = '0;
            rd_d    = '0;
            d1_d    = '0;
            d2_d    = '0;
            imm_d   = '0;
            op_d    = '0;
            ctrl_d  = '0;
        end else if (!bus.es_i_stall) begin
            valid_d = bus.ds_i_valid;
            pc_d    = bus.ds_i_pc;
            rs1_d   = bus.ds_i_addr_rs1;
            rs2_d   = bus.ds_i_addr_rs2;
            rd_d    = bus.ds_i_addr_rd;
            d1_d    = bus.ds_i_data_rs1;
            d2_d    = bus.ds_i_data_rs2;
            imm_d   = bus.ds_i_imm;
            op_d    = bus.ds_i_alu_op;
            // A bubble carries its data fields but never any control side effects
            ctrl_d  = bus.ds_i_valid ? ctrl_in : 5'b0;
        end
    end

    always_comb begin
        scnt_d = scnt_q;
        fcnt_d = fcnt_q;
        if (bus.es_i_stall && !bus.es_i_flush && scnt_q != CNT_MAX)
            scnt_d = scnt_q + CNT_ONE;
        if (bus.es_i_flush && valid_q && fcnt_q != CNT_MAX)
            fcnt_d = fcnt_q + CNT_ONE;
    end

    always_ff @(posedge ds_i_clk or posedge ds_i_rst) begin
        if (ds_i_rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            imm_q   <= '0;
            op_q    <= '0;
            ctrl_q  <= '0;
            scnt_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            imm_q   <= imm_d;
            op_q    <= op_d;
            ctrl_q  <= ctrl_d;
            scnt_q  <= scnt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign bus.ds_o_ready        = !bus.es_i_stall || bus.es_i_flush;
    assign bus.ds_es_o_valid     = valid_q;
    assign bus.ds_es_o_pc        = pc_q;
    assign bus.ds_es_o_addr_rs1  = rs1_q;
    assign bus.ds_es_o_addr_rs2  = rs2_q;
    assign bus.ds_es_o_addr_rd   = rd_q;
    assign bus.ds_es_o_data_rs1  = d1_q;
    assign bus.ds_es_o_data_rs2  = d2_q;
    assign bus.ds_es_o_imm       = imm_q;
    assign bus.ds_es_o_alu_op    = op_q;
    assign bus.ds_es_o_alusrc    = ctrl_q[4] & valid_q;
    assign bus.ds_es_o_regwrite  = ctrl_q[3] & valid_q;
    assign bus.ds_es_o_memread   = ctrl_q[2] & valid_q;
    assign bus.ds_es_o_memwrite  = ctrl_q[1] & valid_q;
    assign bus.ds_es_o_branch    = ctrl_q[0] & valid_q;
    assign bus.ds_es_o_stall_cnt = scnt_q;
    assign bus.ds_es_o_flush_cnt = fcnt_q;
endmodule

// File: tb/tb_ds_es_pipe.sv
// tb/tb_ds_es_pipe.sv - directed table-driven bench for ds_es_pipe
module tb_ds_es_pipe;
    localparam int CW = 4;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [3:0]  op;
        logic [4:0]  ctrl;
    } fields_t;

    typedef struct {
        fields_t       in;
        logic          stall;
        logic          flush;
        fields_t       exp;
        logic [CW-1:0] scnt;
        logic [CW-1:0] fcnt;
        logic          ready;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    fields_t act;
    vec_t vecs[15];

    ds_es_pipe_if #(.CNTW(CW)) bus ();

    ds_es_pipe #(.CNTW(CW)) dut (
        .ds_i_clk (clk),
        .ds_i_rst (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        act = '{valid: bus.ds_es_o_valid, pc: bus.ds_es_o_pc, rs1: bus.ds_es_o_addr_rs1,
                rs2: bus.ds_es_o_addr_rs2, rd: bus.ds_es_o_addr_rd, d1: bus.ds_es_o_data_rs1,
                d2: bus.ds_es_o_data_rs2, imm: bus.ds_es_o_imm, op: bus.ds_es_o_alu_op,
                ctrl: {bus.ds_es_o_alusrc, bus.ds_es_o_regwrite, bus.ds_es_o_memread,
                       bus.ds_es_o_memwrite, bus.ds_es_o_branch}};
    end

    always @(negedge clk) begin
        checks++;
        if (!bus.ds_es_o_valid && (bus.ds_es_o_alusrc || bus.ds_es_o_regwrite ||
            bus.ds_es_o_memread || bus.ds_es_o_memwrite || bus.ds_es_o_branch)) begin
            errors++;
            $display("FAIL ctrl_gating t=%0t valid=0 ctrl=%b", $time, act.ctrl);
        end
    end

    function automatic fields_t mkf(input logic v, input logic [31:0] pc,
                                    input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic [4:0] rd, input logic [31:0] d1,
                                    input logic [31:0] d2, input logic [31:0] imm,
                                    input logic [3:0] op, input logic [4:0] ctrl);
        fields_t f;
        f = '{valid: v, pc: pc, rs1: rs1, rs2: rs2, rd: rd, d1: d1, d2: d2,
              imm: imm, op: op, ctrl: ctrl};
        return f;
    endfunction

    task automatic drive(input fields_t f, input logic stall, input logic flush);
        bus.ds_i_valid    = f.valid;
        bus.ds_i_pc       = f.pc;
        bus.ds_i_addr_rs1 = f.rs1;
        bus.ds_i_addr_rs2 = f.rs2;
        bus.ds_i_addr_rd  = f.rd;
        bus.ds_i_data_rs1 = f.d1;
        bus.ds_i_data_rs2 = f.d2;
        bus.ds_i_imm      = f.imm;
        bus.ds_i_alu_op   = f.op;
        {bus.ds_i_alusrc, bus.ds_i_regwrite, bus.ds_i_memread,
         bus.ds_i_memwrite, bus.ds_i_branch} = f.ctrl;
        bus.es_i_stall    = stall;
        bus.es_i_flush    = flush;
    endtask

    task automatic chk_fields(input string name, input fields_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s fields got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic chk_cnt(input string name, input logic [CW-1:0] s, input logic [CW-1:0] f);
        checks++;
        if (bus.ds_es_o_stall_cnt !== s || bus.ds_es_o_flush_cnt !== f) begin
            errors++;
            $display("FAIL %s counters got stall=%0d flush=%0d want stall=%0d flush=%0d",
                     name, bus.ds_es_o_stall_cnt, bus.ds_es_o_flush_cnt, s, f);
        end
    endtask

    task automatic chk_ready(input string name, input logic r);
        checks++;
        if (bus.ds_o_ready !== r) begin
            errors++;
            $display("FAIL %s ready got=%b want=%b", name, bus.ds_o_ready, r);
        end
    endtask

    fields_t z, f_add, f_lw, f_nx, f_oth, f_bub, f_bubx, f_r0, f_br, f_st;

    initial begin
        z      = '0;
        f_add  = mkf(1, 32'h40, 3, 4, 5, 32'd11, 32'd22, 32'd0, 4'd2, 5'b01000);
        f_lw   = mkf(1, 32'h44, 1, 2, 7, 32'd100, 32'd0, 32'd4, 4'd0, 5'b10100);
        f_nx   = mkf(1, 32'h48, 7, 3, 9, 32'd200, 32'd300, 32'd0, 4'd1, 5'b01000);
        f_oth  = mkf(1, 32'h4c, 8, 8, 10, 32'd1, 32'd2, 32'd3, 4'd3, 5'b00010);
        f_bub  = mkf(0, 32'h58, 6, 6, 6, 32'd77, 32'd88, 32'd99, 4'd5, 5'b01010);
        f_bubx = mkf(0, 32'h58, 6, 6, 6, 32'd77, 32'd88, 32'd99, 4'd5, 5'b00000);
        f_r0   = mkf(1, 32'h60, 0, 0, 0, 32'd5, 32'd6, 32'd7, 4'd2, 5'b01000);
        f_br   = mkf(1, 32'h64, 2, 3, 0, 32'hdeadbeef, 32'h12345678, 32'hfffffff0, 4'd8, 5'b00001);
        f_st   = mkf(1, 32'h68, 4, 5, 0, 32'd1, 32'd2, 32'd8, 4'd0, 5'b10010);

        vecs[0]  = '{f_add, 0, 0, f_add,  0, 0, 1};
        vecs[1]  = '{f_lw,  0, 0, f_lw,   0, 0, 1};
        vecs[2]  = '{f_nx,  1, 0, f_lw,   1, 0, 0};
        vecs[3]  = '{f_oth, 1, 0, f_lw,   2, 0, 0};
        vecs[4]  = '{f_nx,  1, 0, f_lw,   3, 0, 0};
        vecs[5]  = '{f_nx,  0, 0, f_nx,   3, 0, 1};
        vecs[6]  = '{mkf(1, 32'h50, 1, 1, 1, 1, 1, 1, 1, 5'b11111), 1, 1, z, 3, 1, 1};
        vecs[7]  = '{mkf(1, 32'h54, 2, 2, 2, 2, 2, 2, 2, 5'b01000), 0, 1, z, 3, 1, 1};
        vecs[8]  = '{f_bub, 0, 0, f_bubx, 3, 1, 1};
        vecs[9]  = '{f_nx,  1, 0, f_bubx, 4, 1, 0};
        vecs[10] = '{f_r0,  0, 0, f_r0,   4, 1, 1};
        vecs[11] = '{f_nx,  0, 1, z,      4, 2, 1};
        vecs[12] = '{f_br,  0, 0, f_br,   4, 2, 1};
        vecs[13] = '{f_oth, 1, 0, f_br,   5, 2, 0};
        vecs[14] = '{f_st,  0, 0, f_st,   5, 2, 1};

        drive(z, 0, 0);
        #12;
        chk_fields("reset", z);
        chk_cnt("reset", 0, 0);
        #8 rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].in, vecs[i].stall, vecs[i].flush);
            #1 chk_ready($sformatf("vec%0d", i), vecs[i].ready);
            @(posedge clk);
            #1;
            chk_fields($sformatf("vec%0d", i), vecs[i].exp);
            chk_cnt($sformatf("vec%0d", i), vecs[i].scnt, vecs[i].fcnt);
        end

        // Saturation: 20 stall cycles from a cleared counter
        @(negedge clk) rst = 1'b1;
        #1 rst = 1'b0;
        chk_cnt("sat_clear", 0, 0);
        drive(f_add, 1, 0);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1 chk_cnt($sformatf("sat%0d", i), (i > 15) ? 4'd15 : 4'(i), 0);
        end

        // Asynchronous reset in the middle of a stall
        drive(f_lw, 0, 0);
        @(posedge clk);
        #1 chk_fields("ar_load", f_lw);
        drive(f_nx, 1, 0);
        @(posedge clk);
        #1 chk_fields("ar_hold", f_lw);
        #2 rst = 1'b1;
        #1;
        chk_fields("ar_mid", z);
        chk_cnt("ar_mid", 0, 0);
        @(negedge clk) rst = 1'b0;
        drive(f_nx, 0, 0);
        @(posedge clk);
        #1;
        chk_fields("ar_release", f_nx);
        chk_cnt("ar_release", 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ds_es_pipe.md
# ds_es_pipe

Decode-to-execute pipeline register for one issue lane of the dual-issue core; instantiate once per lane. It captures decoded operands, register addresses and control from decode and presents them to execute, to the operand-forwarding logic and to the hazard unit. It also applies load-use stall hold, branch flush and bubble insertion, and keeps saturating stall and flush event counters for performance debug.

## Interface
- AWIDTH, 5, register-address width
- DWIDTH, 32, datapath width for operands and immediate
- PCWIDTH, 32, program-counter width
- ALUOPW, 4, ALU operation code width
- CNTW, 16, performance-counter width
- ds_i_clk  in  1  clock; all state updates on rising edge
- ds_i_rst  in  1  reset, asynchronous, active-high
- ds_i_valid  in  1  decode presents a valid instruction this cycle
- ds_i_pc  in  PCWIDTH  instruction PC
- ds_i_addr_rs1 / ds_i_addr_rs2 / ds_i_addr_rd  in  AWIDTH each  source and destination register addresses
- ds_i_data_rs1 / ds_i_data_rs2  in  DWIDTH each  register-file read data
- ds_i_imm  in  DWIDTH  sign-extended immediate
- ds_i_alu_op  in  ALUOPW  ALU operation
- ds_i_alusrc, ds_i_regwrite, ds_i_memread, ds_i_memwrite, ds_i_branch  in  1 each  control bits
- es_i_stall  in  1  load-use stall from the hazard/forwarding unit
- es_i_flush  in  1  branch-redirect flush from execute
- ds_o_ready  out  1  decode may advance; equals !es_i_stall || es_i_flush
- ds_es_o_valid  out  1  registered valid
- ds_es_o_pc, ds_es_o_addr_rs1, ds_es_o_addr_rs2, ds_es_o_addr_rd, ds_es_o_data_rs1, ds_es_o_data_rs2, ds_es_o_imm, ds_es_o_alu_op  out  matching input widths  registered fields
- ds_es_o_alusrc, ds_es_o_regwrite, ds_es_o_memread, ds_es_o_memwrite, ds_es_o_branch  out  1 each  registered control bits, gated by valid
- ds_es_o_stall_cnt  out  CNTW  cycles with es_i_stall=1 and es_i_flush=0, saturating
- ds_es_o_flush_cnt  out  CNTW  cycles with es_i_flush=1 while ds_es_o_valid=1, saturating

## Operation
- Per-edge action, highest priority first:
  - Flush (es_i_flush=1): valid and all five control bits go to 0; the data, address, PC and imm fields go to 0. Flush overrides stall.
  - Stall (es_i_stall=1, no flush): every field holds its value, including valid and control.
  - Advance (otherwise): every field loads from the ds_i_* inputs.
- Bubble rule: when advancing with ds_i_valid=0, valid and the five control bits load 0. Data, address and PC fields still load from the inputs and are don't-care to consumers.
- Control gating: registered regwrite, memread, memwrite and branch are never 1 while valid is 0. This is an invariant the bench checks every cycle.
- Address rd=0 with regwrite=1 is passed through unchanged. Filtering of register 0 is done downstream.
- ds_o_ready is combinational from es_i_stall and es_i_flush only. It has no dependence on ds_i_valid.
- Counters:
  - Each counter increments by 1 under its condition and saturates at all-ones; it never wraps.
  - The stall and flush counters update independently in the same cycle when both conditions hold.
  - es_i_stall with es_i_flush counts only as a flush.
  - Counters clear only on reset.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on ds_es_o_* after edge N.
- Stall hold is unbounded. Consecutive stall cycles keep the same instruction, and each cycle adds 1 to the stall count.
- A flush on a cycle when valid=0 still clears the register but does not increment flush_cnt.
- Reset (asynchronous, any time, including mid-stall) forces every ds_es_o_* output and both counters to 0 immediately. On release, the first rising edge performs a normal advance.
- No combinational path from ds_i_* to ds_es_o_*.

## Test plan
- Advance: valid=1, pc=0x40, rs1=3, rs2=4, rd=5, regwrite=1, alu_op=2 -> one cycle later the outputs show the same values with valid=1; stall_cnt and flush_cnt stay 0.
- Stall hold: load a valid lw (memread=1, rd=7), then hold es_i_stall=1 for 3 cycles while the inputs change -> outputs stay the lw; ds_o_ready=0 throughout; stall_cnt=3. When stall drops, the next edge loads the new inputs.
- Flush over stall: register holds a valid instruction; es_i_stall=1 and es_i_flush=1 in the same cycle -> next cycle valid=0, all controls 0, fields 0; flush_cnt=1, stall_cnt=0; ds_o_ready=1.
- Bubble: advance with ds_i_valid=0, ds_i_regwrite=1, ds_i_memwrite=1 -> ds_es_o_valid=0, regwrite=0, memwrite=0.
- Saturation: with CNTW=4, hold stall for 20 cycles -> stall_cnt reaches 15 and remains 15.
- Async reset mid-stall: assert ds_i_rst between clock edges during a stall -> all outputs and counters are 0 before the next edge. After release, the first edge with valid=1 loads normally.
